// File: rtl/bounds_drawer.sv
// Bounds drawer: on a held draw_bounds request, raster-scans the playfield
// once, emitting one registered pixel per cycle (walls, goal openings, centre
// line), then holds done_bounds until the request is withdrawn.
//
// Handshake: draw_bounds is a level request. The block answers with a pixel
// stream (plot = 1 qualifies x/y/colour) followed by done_bounds, which stays
// high for as long as draw_bounds does. Dropping draw_bounds mid-scan aborts
// the scan and no done_bounds is produced for it.
module bounds_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int BORDER = 2,
  parameter int GOAL_H = 40,
  parameter logic [2:0] WALL_COLOUR = 3'b111,
  parameter logic [2:0] MID_COLOUR = 3'b001
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           draw_bounds,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           done_bounds,
  output logic           busy,
  output logic [1:0]     debug_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Geometry constants, pre-sized to the counter widths.
  localparam logic [X_W-1:0] X_LAST   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] X_LWALL  = X_W'(BORDER);
  localparam logic [X_W-1:0] X_RWALL  = X_W'(SCREEN_W - BORDER);
  localparam logic [Y_W-1:0] Y_TWALL  = Y_W'(BORDER);
  localparam logic [Y_W-1:0] Y_BWALL  = Y_W'(SCREEN_H - BORDER);
  localparam logic [Y_W-1:0] Y_GOAL_L = Y_W'((SCREEN_H - GOAL_H) / 2);
  localparam logic [Y_W-1:0] Y_GOAL_H = Y_W'((SCREEN_H - GOAL_H) / 2 + GOAL_H);
  localparam logic [X_W-1:0] X_MID    = X_W'(SCREEN_W / 2);

  logic [1:0]     state;
  logic [X_W-1:0] x_inc;
  logic [Y_W-1:0] y_inc;

  // Colour of a pixel; walls win over the goal gap, the gap over the centre line.
  function automatic logic [2:0] pixel_colour(input logic [X_W-1:0] px,
                                              input logic [Y_W-1:0] py);
    logic [2:0] c;
    c = 3'b000;
    if (py < Y_TWALL || py >= Y_BWALL) begin
      c = WALL_COLOUR;
    end else if (px < X_LWALL || px >= X_RWALL) begin
      if (py >= Y_GOAL_L && py < Y_GOAL_H) c = 3'b000;
      else c = WALL_COLOUR;
    end else if (px == X_MID) begin
      c = MID_COLOUR;
    end
    return c;
  endfunction

  assign x_inc = x + 1'b1;
  assign y_inc = y + 1'b1;
  assign debug_state = state;

  // Scan sequencer: state, pixel counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      colour      <= 3'b000;
      plot        <= 1'b0;
      done_bounds <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (draw_bounds) begin
            state       <= SCAN;
            x           <= '0;
            y           <= '0;
            colour      <= pixel_colour('0, '0);
            plot        <= 1'b1;
            busy        <= 1'b1;
            done_bounds <= 1'b0;
          end
        end
        SCAN: begin
          if (!draw_bounds) begin
            // Aborted scan: quiet outputs, no done for this request.
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            colour <= 3'b000;
            plot   <= 1'b0;
            busy   <= 1'b0;
          end else if (x == X_LAST && y == Y_LAST) begin
            state       <= DONE;
            x           <= '0;
            y           <= '0;
            colour      <= 3'b000;
            plot        <= 1'b0;
            busy        <= 1'b0;
            done_bounds <= 1'b1;
          end else if (x == X_LAST) begin
            x      <= '0;
            y      <= y_inc;
            colour <= pixel_colour('0, y_inc);
          end else begin
            x      <= x_inc;
            colour <= pixel_colour(x_inc, y);
          end
        end
        DONE: begin
          if (!draw_bounds) begin
            state       <= IDLE;
            done_bounds <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          x           <= '0;
          y           <= '0;
          colour      <= 3'b000;
          plot        <= 1'b0;
          busy        <= 1'b0;
          done_bounds <= 1'b0;
        end
      endcase
    end
  end

endmodule
